// File: rtl/instr_exec_unit.sv
// Execution stage: fetches stored instructions in order, evaluates each one and
// returns a signed 64-bit result per instruction over a valid/ready handshake.
module instr_exec_unit #(
    parameter int unsigned OP_W   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RES_W  = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_instr,
    output logic [ADDR_W-1:0]       read_pointer,
    input  logic [3:0]              instr_opc,
    input  logic signed [OP_W-1:0]  instr_op_a,
    input  logic signed [OP_W-1:0]  instr_op_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] result,
    output logic [ADDR_W-1:0]       res_index,
    output logic                    res_err,
    output logic                    busy,
    output logic                    done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_DIVIDE = 3'd3;
    localparam logic [2:0] ST_FIX    = 3'd4;
    localparam logic [2:0] ST_OUTPUT = 3'd5;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    localparam int unsigned CNT_W     = $clog2(OP_W);
    localparam int unsigned EXT_W     = RES_W - OP_W;
    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(OP_W - 1);

    logic [2:0]              state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [ADDR_W:0]         count_q, count_d;
    logic [3:0]              opc_q, opc_d;
    logic signed [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic signed [RES_W-1:0] result_q, result_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic [OP_W-1:0]         rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [RES_W-1:0] a_ext, b_ext, q_ext, r_ext;
    logic [OP_W-1:0]         a_mag, b_mag;
    logic [OP_W:0]           rem_shift, rem_diff;

    assign a_ext = {{EXT_W{a_q[OP_W-1]}}, a_q};
    assign b_ext = {{EXT_W{b_q[OP_W-1]}}, b_q};
    assign a_mag = a_q[OP_W-1] ? ('0 - a_q) : a_q;
    assign b_mag = b_q[OP_W-1] ? ('0 - b_q) : b_q;
    // Magnitude of -2^(OP_W-1) still fits unsigned OP_W bits, so no overflow here.
    assign q_ext = {{EXT_W{1'b0}}, quo_q};
    assign r_ext = {{EXT_W{1'b0}}, rem_q};
    assign rem_shift = {rem_q, quo_q[OP_W-1]};
    assign rem_diff  = rem_shift - {1'b0, div_q};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        opc_d    = opc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_instr == '0) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = (num_instr > MAX_N) ? MAX_N : num_instr;
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                opc_d   = instr_opc;
                a_d     = instr_op_a;
                b_d     = instr_op_b;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                err_d   = 1'b0;
                state_d = ST_OUTPUT;
                case (opc_q)
                    OPC_ZERO:  result_d = '0;
                    OPC_PASSA: result_d = a_ext;
                    OPC_PASSB: result_d = b_ext;
                    OPC_ADD:   result_d = a_ext + b_ext;
                    OPC_SUB:   result_d = a_ext - b_ext;
                    OPC_MULT:  result_d = a_ext * b_ext;
                    OPC_DIV, OPC_MOD: begin
                        if (b_q == '0) begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_mag;
                            div_d   = b_mag;
                            cnt_d   = '0;
                            state_d = ST_DIVIDE;
                        end
                    end
                    default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                endcase
            end
            ST_DIVIDE: begin
                if (rem_shift >= {1'b0, div_q}) begin
                    rem_d = rem_diff[OP_W-1:0];
                    quo_d = {quo_q[OP_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[OP_W-1:0];
                    quo_d = {quo_q[OP_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + DIV_ONE;
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Truncating division: quotient sign from a^b, remainder follows a.
                if (opc_q == OPC_DIV) begin
                    result_d = (a_q[OP_W-1] ^ b_q[OP_W-1]) ? ('0 - q_ext) : q_ext;
                end else begin
                    result_d = a_q[OP_W-1] ? ('0 - r_ext) : r_ext;
                end
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (res_ready) begin
                    if ({1'b0, idx_q} == count_q - CNT_ONE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            opc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            opc_q    <= opc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
        end
    end

    // idx only changes when entering FETCH, so it doubles as the held read pointer.
    assign read_pointer = idx_q;
    assign res_index    = idx_q;
    assign result       = result_q;
    assign res_err      = err_q;
    assign res_valid    = (state_q == ST_OUTPUT);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

endmodule
